wb_arbiter2: RTL and testbench
==============================

WB_ARBITER2 -- requirements
Module: wb_arbiter2

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of all data buses.
REQ-002 SHALL have parameter ADR_BITS, default 30, word-address width (XLEN-2).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, stalled-strobe cycles before bus error (8-bit range, 1..255).
REQ-004 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have ports m0_cyc_i/m0_stb_i/m0_we_i  input  1 each  master 0 (CPU) Wishbone controls.
REQ-007 SHALL have ports m0_adr_i  input  ADR_BITS, m0_sel_i  input  4, m0_dat_i  input  XLEN  master 0 address/select/write data.
REQ-008 SHALL have ports m0_dat_o  output  XLEN, m0_ack_o/m0_err_o  output  1  master 0 read data and termination.
REQ-009 SHALL have the identical m1_* port set for master 1 (DMA/blitter).
REQ-010 SHALL have ports s_cyc_o/s_stb_o/s_we_o  output  1, s_adr_o  output  ADR_BITS, s_sel_o  output  4, s_dat_o  output  XLEN  shared slave bus.
REQ-011 SHALL have ports s_dat_i  input  XLEN, s_ack_i/s_err_i  input  1  shared slave response (already decoded downstream).
REQ-012 SHALL have port gnt_o  output  2  one-hot current grant {m1,m0}.

Function
REQ-013 SHALL implement FSM states IDLE, GNT0, GNT1; gnt_o = {state==GNT1, state==GNT0}.
REQ-014 IDLE: only m0_cyc_i -> GNT0; only m1_cyc_i -> GNT1; both -> master not granted last (last_q), round-robin; neither -> stay.
REQ-015 GNTx SHALL hold while mx_cyc_i=1 (bus lock across multi-beat cycles); mx_cyc_i=0 -> IDLE; no direct GNT0<->GNT1 transition.
REQ-016 last_q SHALL update to x on entry to GNTx.
REQ-017 Slave outputs SHALL be combinational muxes of granted master's cyc/stb/we/adr/sel/dat; in IDLE s_cyc_o=s_stb_o=s_we_o=0, s_adr_o=0, s_sel_o=0, s_dat_o=0.
REQ-018 Granted master SHALL receive s_dat_i, s_ack_i, s_err_i (OR timeout error) combinationally; non-granted master SHALL see dat_o=0, ack_o=0, err_o=0.
REQ-019 Latency: request seen in IDLE at edge N -> grant valid after edge N; slave strobe earliest in cycle after edge N; zero added latency on responses.
REQ-020 Requester not granted SHALL simply wait (stalled, no ack); no request is dropped.
REQ-021 ack/err arriving in the same cycle the granted master drops cyc SHALL still be forwarded; FSM returns to IDLE at that edge.

Reset
REQ-022 rst_ni low SHALL asynchronously force state=IDLE, last_q=1 (m0 wins first tie), timeout counter=0; thus gnt_o=0 and all slave and master outputs 0.
REQ-023 Reset mid-transfer SHALL abort immediately; no ack/err forwarded during reset; arbitration restarts from IDLE after release.

Configuration
REQ-024 Macro WB_ARB_TIMEOUT_EN defined: 8-bit counter increments each cycle s_stb_o=1 and s_ack_i=s_err_i=0, clears otherwise; on reaching TIMEOUT_CYCLES SHALL assert err to granted master for exactly one cycle and clear.
REQ-025 Macro undefined: no counter logic; err path is s_err_i passthrough only; stalled slave stalls master indefinitely.

Structure
REQ-026 Shared package/header SHALL hold state encodings (IDLE=2'd0, GNT0=2'd1, GNT1=2'd2) and default TIMEOUT_CYCLES.
REQ-027 Single module; timeout counter MAY be sub-module wb_timeout; no other hierarchy.

Verification
REQ-028 m0 only: cyc/stb, adr=0x3_0010, slave ack next cycle with dat 0xDEADBEEF -> gnt_o=01, m0_dat_o=0xDEADBEEF, m0_ack_o=1, m1 outputs 0.
REQ-029 Both request in IDLE after reset -> GNT0 first; m0 drops cyc -> IDLE -> GNT1 (round robin); next tie -> GNT0.
REQ-030 m0 holds cyc for 4 beats while m1 requests -> gnt_o stays 01 all 4 beats; m1_ack_o=0 throughout; GNT1 two edges after m0 cyc falls.
REQ-031 With WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks -> m0_err_o=1 for one cycle, 8 cycles after stb; without macro -> no err after 1000 cycles.
REQ-032 rst_ni low mid-beat (GNT1, stb=1) -> same-cycle s_cyc_o=0, gnt_o=00; after release m0 request granted first.
REQ-033 s_err_i=1 during GNT1 -> m1_err_o=1 same cycle, m0_err_o=0.

Source files
------------

// File: rtl/wb_arbiter2_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: FSM state
// encodings and the default stalled-strobe timeout.
package wb_arbiter2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  // Default number of stalled strobe cycles before a bus error is raised
  // (only used when the arbiter is built with WB_ARB_TIMEOUT_EN).
  localparam int TIMEOUT_CYCLES_DEF = 255;

  // Width of the stalled-strobe counter.
  localparam int TMO_W = 8;

endpackage

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone arbiter (m0 = CPU, m1 = DMA/blitter) onto one shared
// slave bus. Round-robin on simultaneous requests, bus held for the whole
// of a master's cyc. Slave-side outputs and master-side responses are pure
// muxes of the registered grant, so responses pass with zero added latency.
//
// Optional feature: define WB_ARB_TIMEOUT_EN to add an 8-bit stalled-strobe
// counter that terminates a hung transfer with a one-cycle bus error after
// TIMEOUT_CYCLES cycles. Without the macro, err is a plain s_err_i passthrough.
module wb_arbiter2
  import wb_arbiter2_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int ADR_BITS       = 30,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                clk_i,
  input  logic                rst_ni,

  // Master 0 (CPU)
  input  logic                m0_cyc_i,
  input  logic                m0_stb_i,
  input  logic                m0_we_i,
  input  logic [ADR_BITS-1:0] m0_adr_i,
  input  logic [3:0]          m0_sel_i,
  input  logic [XLEN-1:0]     m0_dat_i,
  output logic [XLEN-1:0]     m0_dat_o,
  output logic                m0_ack_o,
  output logic                m0_err_o,

  // Master 1 (DMA / blitter)
  input  logic                m1_cyc_i,
  input  logic                m1_stb_i,
  input  logic                m1_we_i,
  input  logic [ADR_BITS-1:0] m1_adr_i,
  input  logic [3:0]          m1_sel_i,
  input  logic [XLEN-1:0]     m1_dat_i,
  output logic [XLEN-1:0]     m1_dat_o,
  output logic                m1_ack_o,
  output logic                m1_err_o,

  // Shared slave bus
  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic                s_we_o,
  output logic [ADR_BITS-1:0] s_adr_o,
  output logic [3:0]          s_sel_o,
  output logic [XLEN-1:0]     s_dat_o,
  input  logic [XLEN-1:0]     s_dat_i,
  input  logic                s_ack_i,
  input  logic                s_err_i,

  // One-hot current grant {m1, m0}
  output logic [1:0]          gnt_o
);

  arb_state_e state_q;
  logic       last_q;     // 0: m0 was granted last, 1: m1 was granted last
  logic       gnt0;
  logic       gnt1;
  logic       tmo_err;

  assign gnt0  = (state_q == GNT0);
  assign gnt1  = (state_q == GNT1);
  assign gnt_o = {gnt1, gnt0};

  // Grant FSM: arbitrate only from IDLE, then hold the bus until the owner drops cyc.
  // NOTE: state is reset asynchronously so the grant (and with it every bus
  // output) collapses the instant rst_ni falls, not at the next clock edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
            state_q <= GNT0;
            last_q  <= 1'b0;
          end else if (m1_cyc_i) begin
            state_q <= GNT1;
            last_q  <= 1'b1;
          end
        end
        GNT0:    if (!m0_cyc_i) state_q <= IDLE;
        GNT1:    if (!m1_cyc_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Slave-side request mux: the granted master drives the shared bus, IDLE drives zeros.
  // NOTE: every output gets a default before the branches so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_sel_o = '0;
    s_dat_o = '0;
    if (gnt0) begin
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i;
      s_we_o  = m0_we_i;
      s_adr_o = m0_adr_i;
      s_sel_o = m0_sel_i;
      s_dat_o = m0_dat_i;
    end else if (gnt1) begin
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i;
      s_we_o  = m1_we_i;
      s_adr_o = m1_adr_i;
      s_sel_o = m1_sel_i;
      s_dat_o = m1_dat_i;
    end
  end

  // Master-side response demux: only the granted master sees the slave's reply.
  assign m0_dat_o = gnt0 ? s_dat_i : '0;
  assign m0_ack_o = gnt0 & s_ack_i;
  assign m0_err_o = gnt0 & (s_err_i | tmo_err);

  assign m1_dat_o = gnt1 ? s_dat_i : '0;
  assign m1_ack_o = gnt1 & s_ack_i;
  assign m1_err_o = gnt1 & (s_err_i | tmo_err);

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

  logic [TMO_W-1:0] tmo_cnt_q;
  logic             stalled;

  assign stalled = s_stb_o & ~s_ack_i & ~s_err_i;
  assign tmo_err = (tmo_cnt_q == TMO_LIMIT);

  // Stalled-strobe counter: counts unanswered strobe cycles, clears on any
  // termination, on a dropped strobe, and right after it fires an error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt_q <= '0;
    end else if (tmo_err || !stalled) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end
`else
  // No timeout: a stalled slave stalls the master indefinitely.
  logic unused_tmo_cfg;

  assign tmo_err        = 1'b0;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_wb_arbiter2.sv
// Self-checking bench for wb_arbiter2: a table of single-cycle vectors with
// hand-computed outputs, followed by hand-written multi-cycle sequences for
// bus lock, round robin, timeout and mid-transfer reset.
module tb_wb_arbiter2;

  localparam logic [29:0] A0 = 30'h3_0010;
  localparam logic [29:0] A1 = 30'h000_2000;
  localparam logic [31:0] D0 = 32'h1111_A0A0;
  localparam logic [31:0] D1 = 32'h2222_B1B1;
  localparam logic [3:0]  S0 = 4'hF;
  localparam logic [3:0]  S1 = 4'h3;

  logic        clk;
  logic        rst_n;
  logic        m0_cyc, m0_stb, m0_we;
  logic [29:0] m0_adr;
  logic [3:0]  m0_sel;
  logic [31:0] m0_dat_w, m0_dat_r;
  logic        m0_ack, m0_err;
  logic        m1_cyc, m1_stb, m1_we;
  logic [29:0] m1_adr;
  logic [3:0]  m1_sel;
  logic [31:0] m1_dat_w, m1_dat_r;
  logic        m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we;
  logic [29:0] s_adr;
  logic [3:0]  s_sel;
  logic [31:0] s_dat_w, s_dat_r;
  logic        s_ack, s_err;
  logic [1:0]  gnt;

  int n_vec = 0;
  int n_bad = 0;

  wb_arbiter2 #(
    .XLEN(32),
    .ADR_BITS(30),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .m0_cyc_i(m0_cyc),
    .m0_stb_i(m0_stb),
    .m0_we_i (m0_we),
    .m0_adr_i(m0_adr),
    .m0_sel_i(m0_sel),
    .m0_dat_i(m0_dat_w),
    .m0_dat_o(m0_dat_r),
    .m0_ack_o(m0_ack),
    .m0_err_o(m0_err),
    .m1_cyc_i(m1_cyc),
    .m1_stb_i(m1_stb),
    .m1_we_i (m1_we),
    .m1_adr_i(m1_adr),
    .m1_sel_i(m1_sel),
    .m1_dat_i(m1_dat_w),
    .m1_dat_o(m1_dat_r),
    .m1_ack_o(m1_ack),
    .m1_err_o(m1_err),
    .s_cyc_o (s_cyc),
    .s_stb_o (s_stb),
    .s_we_o  (s_we),
    .s_adr_o (s_adr),
    .s_sel_o (s_sel),
    .s_dat_o (s_dat_w),
    .s_dat_i (s_dat_r),
    .s_ack_i (s_ack),
    .s_err_i (s_err),
    .gnt_o   (gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All observable outputs packed in one word for compact comparison.
  logic [138:0] outs;
  assign outs = {gnt, s_cyc, s_stb, s_we, s_adr, s_sel, s_dat_w,
                 m0_dat_r, m0_ack, m0_err, m1_dat_r, m1_ack, m1_err};

  typedef struct {
    logic [2:0]  m0_ctl;    // {cyc, stb, we}
    logic [2:0]  m1_ctl;    // {cyc, stb, we}
    logic [31:0] s_dat;
    logic [1:0]  s_rsp;     // {ack, err}
    logic [1:0]  e_gnt;
    logic [2:0]  e_s_ctl;   // {cyc, stb, we}
    logic [29:0] e_s_adr;
    logic [3:0]  e_s_sel;
    logic [31:0] e_s_dat;
    logic [31:0] e_m0_dat;
    logic [1:0]  e_m0_rsp;  // {ack, err}
    logic [31:0] e_m1_dat;
    logic [1:0]  e_m1_rsp;  // {ack, err}
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
    s_dat_r = 32'h0; s_ack = 1'b0; s_err = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    {m0_cyc, m0_stb, m0_we} = v.m0_ctl;
    {m1_cyc, m1_stb, m1_we} = v.m1_ctl;
    s_dat_r                 = v.s_dat;
    {s_ack, s_err}          = v.s_rsp;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Master address/data/select are fixed per master for the whole run.
    m0_adr = A0; m0_sel = S0; m0_dat_w = D0;
    m1_adr = A1; m1_sel = S1; m1_dat_w = D1;
    idle_inputs();
    rst_n = 1'b0;

    // Stimulus table: each row is applied after a falling edge and checked
    // before the next rising edge, so the grant reflects earlier rows.
    vecs[0]  = '{3'b000, 3'b000, 32'h0,        2'b00, 2'b00, 3'b000, 30'h0, 4'h0, 32'h0, 32'h0,        2'b00, 32'h0,        2'b00};
    vecs[1]  = '{3'b110, 3'b000, 32'h0,        2'b00, 2'b00, 3'b000, 30'h0, 4'h0, 32'h0, 32'h0,        2'b00, 32'h0,        2'b00};
    vecs[2]  = '{3'b110, 3'b000, 32'hDEADBEEF, 2'b10, 2'b01, 3'b110, A0,    S0,   D0,    32'hDEADBEEF, 2'b10, 32'h0,        2'b00};
    vecs[3]  = '{3'b000, 3'b000, 32'h0,        2'b00, 2'b01, 3'b000, A0,    S0,   D0,    32'h0,        2'b00, 32'h0,        2'b00};
    vecs[4]  = '{3'b111, 3'b111, 32'h0,        2'b00, 2'b00, 3'b000, 30'h0, 4'h0, 32'h0, 32'h0,        2'b00, 32'h0,        2'b00};
    vecs[5]  = '{3'b111, 3'b111, 32'h0,        2'b01, 2'b10, 3'b111, A1,    S1,   D1,    32'h0,        2'b00, 32'h0,        2'b01};
    vecs[6]  = '{3'b111, 3'b000, 32'hCAFEF00D, 2'b10, 2'b10, 3'b000, A1,    S1,   D1,    32'h0,        2'b00, 32'hCAFEF00D, 2'b10};
    vecs[7]  = '{3'b111, 3'b000, 32'h0,        2'b00, 2'b00, 3'b000, 30'h0, 4'h0, 32'h0, 32'h0,        2'b00, 32'h0,        2'b00};
    vecs[8]  = '{3'b111, 3'b000, 32'h0,        2'b00, 2'b01, 3'b111, A0,    S0,   D0,    32'h0,        2'b00, 32'h0,        2'b00};
    vecs[9]  = '{3'b101, 3'b110, 32'h0,        2'b00, 2'b01, 3'b101, A0,    S0,   D0,    32'h0,        2'b00, 32'h0,        2'b00};
    vecs[10] = '{3'b000, 3'b110, 32'h0,        2'b00, 2'b01, 3'b000, A0,    S0,   D0,    32'h0,        2'b00, 32'h0,        2'b00};
    vecs[11] = '{3'b000, 3'b110, 32'h0,        2'b00, 2'b00, 3'b000, 30'h0, 4'h0, 32'h0, 32'h0,        2'b00, 32'h0,        2'b00};
    vecs[12] = '{3'b000, 3'b110, 32'h12345678, 2'b10, 2'b10, 3'b110, A1,    S1,   D1,    32'h0,        2'b00, 32'h12345678, 2'b10};

    // Reset state: outputs stay zero even with requests and responses active.
    #2;
    m0_cyc = 1'b1; m0_stb = 1'b1; s_ack = 1'b1; s_err = 1'b1; s_dat_r = 32'hFFFF_FFFF;
    @(negedge clk);
    #1 check("reset_outputs", 160'(outs), 160'h0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1 check($sformatf("vec%0d", i), 160'(outs),
               160'({vecs[i].e_gnt, vecs[i].e_s_ctl, vecs[i].e_s_adr, vecs[i].e_s_sel,
                     vecs[i].e_s_dat, vecs[i].e_m0_dat, vecs[i].e_m0_rsp,
                     vecs[i].e_m1_dat, vecs[i].e_m1_rsp}));
    end

    // Tie after reset goes to m0, m0 keeps the bus for four beats, then m1
    // is granted two edges after m0 drops cyc, then the next tie goes to m0.
    do_reset();
    @(negedge clk);
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    #1 check("tie_idle", 160'(gnt), 160'(2'b00));
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      s_ack = 1'b1; s_dat_r = 32'(b);
      #1 check($sformatf("lock_beat%0d", b), 160'({gnt, m0_ack, m1_ack, m1_dat_r}),
               160'({2'b01, 1'b1, 1'b0, 32'h0}));
    end
    @(negedge clk);
    m0_cyc = 1'b0; m0_stb = 1'b0; s_ack = 1'b0;
    #1 check("m0_drop", 160'(gnt), 160'(2'b01));
    @(negedge clk);
    #1 check("drop_plus1", 160'(gnt), 160'(2'b00));
    @(negedge clk);
    #1 check("drop_plus2", 160'({gnt, s_cyc, s_adr}), 160'({2'b10, 1'b1, A1}));
    @(negedge clk);
    m1_cyc = 1'b0; m1_stb = 1'b0;
    #1 check("m1_drop", 160'(gnt), 160'(2'b10));
    @(negedge clk);
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    #1 check("tie2_idle", 160'(gnt), 160'(2'b00));
    @(negedge clk);
    #1 check("tie2_gnt0", 160'(gnt), 160'(2'b01));

    // Stalled slave: m0 strobes and the slave never answers.
    do_reset();
    @(negedge clk);
    m0_cyc = 1'b1; m0_stb = 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1 check($sformatf("tmo_cycle%0d", c), 160'({m0_err, m1_err}), 160'({(c == 8), 1'b0}));
    end
`else
    begin
      logic err_seen;
      err_seen = 1'b0;
      for (int c = 0; c < 1000; c++) begin
        @(negedge clk);
        #1 if (m0_err) err_seen = 1'b1;
      end
      check("no_timeout", 160'({err_seen, s_stb, gnt}), 160'({1'b0, 1'b1, 2'b01}));
    end
`endif

    // Reset in the middle of an m1 beat aborts at once; m0 wins afterwards.
    do_reset();
    @(negedge clk);
    m1_cyc = 1'b1; m1_stb = 1'b1;
    @(negedge clk);
    #1 check("pre_abort", 160'({gnt, s_cyc}), 160'({2'b10, 1'b1}));
    #2;
    s_ack = 1'b1; s_err = 1'b1;
    rst_n = 1'b0;
    #1 check("abort", 160'({gnt, s_cyc, s_stb, m1_ack, m1_err, m0_ack, m0_err}), 160'h0);
    @(negedge clk);
    rst_n = 1'b1;
    s_ack = 1'b0; s_err = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b1;
    @(negedge clk);
    #1 check("post_abort", 160'({gnt, s_adr}), 160'({2'b01, A0}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
